// File: rtl/can_tx_pkg.sv
// Shared types and bus-level constants for the CAN transmit bit serializer.
package can_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2
    } tx_state_t;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

endpackage

// File: rtl/can_stuff_counter.sv
// Run-length tracker for driven bus bits; flags when the closing bit completes a stuffable run.
// Built only when CAN_STUFF_EN is defined.
`ifdef CAN_STUFF_EN
module can_stuff_counter #(
    parameter int STUFF_LEN = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic strobe,
    input  logic bit_val,
    output logic stuff_due
);

    localparam int CW = $clog2(STUFF_LEN + 1);

    logic [CW-1:0] run_q;
    logic          last_q;
    logic          same;

    // run_q == 0 means no bit of the current frame has been driven yet
    assign same      = (run_q != '0) && (bit_val == last_q);
    assign stuff_due = strobe && same && (run_q == CW'(STUFF_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else if (strobe) begin
            last_q <= bit_val;
            if (!same)
                run_q <= CW'(1);
            else if (run_q != CW'(STUFF_LEN))
                run_q <= run_q + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/can_bit_serializer.sv
// CAN transmit serializer: MSB-first frame drive with wired-AND arbitration readback.
// Optional bit stuffing enabled by defining CAN_STUFF_EN.
//
//   state | meaning
//   IDLE  | bus recessive, ready to accept a frame
//   SEND  | driving the frame bit picked by the one-hot selector
//   STUFF | driving the complement of the previous bit for one bit time
import can_tx_pkg::*;

module can_bit_serializer #(
    parameter int HEAD      = 7,
    parameter int STUFF_LEN = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          rx,
    input  logic [HEAD:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic          lost
);

    localparam logic [HEAD:0] SEL_FIRST = {1'b1, {HEAD{1'b0}}};

    tx_state_t     state_q, state_nx;
    logic [HEAD:0] shreg_q;
    logic [HEAD:0] sel_q;
    logic [HEAD:0] sel_rot;
    logic          tx_q;
    logic          done_q;
    logic          lost_q;
    logic          accept;
    logic          closing;
    logic          arb_lost;
    logic          stuff_due;

    assign accept   = (state_q == IDLE) && din_valid;
    assign closing  = en && (state_q != IDLE);
    assign arb_lost = closing && (tx_q == CAN_RECESSIVE) && (rx == CAN_DOMINANT);
    assign sel_rot  = {sel_q[0], sel_q[HEAD:1]};

`ifdef CAN_STUFF_EN
    can_stuff_counter #(
        .STUFF_LEN (STUFF_LEN)
    ) u_stuff_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .strobe    (closing),
        .bit_val   (tx_q),
        .stuff_due (stuff_due)
    );
`else
    logic unused_stuff_cfg;
    assign unused_stuff_cfg = (STUFF_LEN > 0);
    assign stuff_due        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE: begin
                if (din_valid)
                    state_nx = SEND;
            end
            SEND: begin
                if (en) begin
                    if (arb_lost || sel_q[0])
                        state_nx = IDLE;
                    else if (stuff_due)
                        state_nx = STUFF;
                end
            end
`ifdef CAN_STUFF_EN
            STUFF: begin
                if (en)
                    state_nx = arb_lost ? IDLE : SEND;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        din_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        tx        = tx_q;
        done      = done_q;
        lost      = lost_q;
    end

    // tx is always registered so neither din nor rx reaches the bus pin combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            sel_q   <= SEL_FIRST;
            tx_q    <= CAN_RECESSIVE;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            lost_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= CAN_RECESSIVE;
                    if (accept) begin
                        shreg_q <= din;
                        sel_q   <= SEL_FIRST;
                        tx_q    <= din[HEAD];
                    end
                end
                SEND: begin
                    if (en) begin
                        if (arb_lost) begin
                            lost_q <= 1'b1;
                            tx_q   <= CAN_RECESSIVE;
                        end else if (sel_q[0]) begin
                            done_q <= 1'b1;
                            tx_q   <= CAN_RECESSIVE;
                        end else if (stuff_due) begin
                            sel_q <= sel_rot;
                            tx_q  <= ~tx_q;
                        end else begin
                            sel_q <= sel_rot;
                            tx_q  <= |(shreg_q & sel_rot);
                        end
                    end
                end
`ifdef CAN_STUFF_EN
                STUFF: begin
                    // selector already advanced when the stuff bit was entered
                    if (en) begin
                        if (arb_lost) begin
                            lost_q <= 1'b1;
                            tx_q   <= CAN_RECESSIVE;
                        end else begin
                            tx_q <= |(shreg_q & sel_q);
                        end
                    end
                end
`endif
                default: tx_q <= CAN_RECESSIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_can_bit_serializer.sv
// Self-checking bench for can_bit_serializer: directed frames plus random frames against a bit-list model.
module tb_can_bit_serializer;

    localparam int HEAD      = 7;
    localparam int STUFF_LEN = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rx;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        tx;
    logic        busy;
    logic        done;
    logic        lost;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    can_bit_serializer #(.HEAD(HEAD), .STUFF_LEN(STUFF_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rx        (rx),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bits as they should appear on the bus, MSB first, with stuff bits when enabled.
    function automatic void build(input logic [7:0] d);
        int  run;
        bit  last;
        bit  b;
        exp_q.delete();
        run  = 0;
        last = 1'b0;
        for (int i = HEAD; i >= 0; i--) begin
            b = d[i];
            run = (run > 0 && b == last) ? run + 1 : 1;
            last = b;
            exp_q.push_back(b);
`ifdef CAN_STUFF_EN
            if (run == STUFF_LEN && i != 0) begin
                exp_q.push_back(~b);
                last = ~b;
                run  = 1;
            end
`endif
        end
    endfunction

    task automatic start_frame(input logic [7:0] d, input logic en_at_accept);
        build(d);
        chk("ready_before_accept", din_ready, 1'b1);
        din       = d;
        din_valid = 1'b1;
        en        = en_at_accept;
        cyc();
        din_valid = 1'b0;
        en        = 1'b0;
        din       = 8'($urandom);
    endtask

    // lose_at: 1-based en index at which rx is forced dominant (0 = never)
    task automatic run_frame(input int lose_at, input bit rx_dom_all, input int reset_after);
        int gap;
        bit los;
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            chk("tx_bit", tx, exp_q[idx]);
            chk("busy", busy, 1'b1);
            chk("ready_while_busy", din_ready, 1'b0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cyc();
                chk("tx_hold", tx, exp_q[idx]);
            end
            en = 1'b1;
            rx = (lose_at == idx + 1 || rx_dom_all) ? 1'b0 : exp_q[idx];
            los = exp_q[idx] && !rx;
            cyc();
            en = 1'b0;
            rx = 1'b1;
            if (los) begin
                chk("lost_pulse", lost, 1'b1);
                chk("no_done_on_loss", done, 1'b0);
                chk("tx_after_loss", tx, 1'b1);
                chk("ready_after_loss", din_ready, 1'b1);
                return;
            end
            if (idx == exp_q.size() - 1) begin
                chk("done_pulse", done, 1'b1);
                chk("no_lost_on_done", lost, 1'b0);
                chk("tx_after_done", tx, 1'b1);
                chk("ready_after_done", din_ready, 1'b1);
                return;
            end
            chk("no_done_mid", done, 1'b0);
            chk("no_lost_mid", lost, 1'b0);
            if (reset_after == idx + 1) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                chk("rst_tx", tx, 1'b1);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_lost", lost, 1'b0);
                cyc();
                chk("rst_done_after", done, 1'b0);
                chk("rst_lost_after", lost, 1'b0);
                return;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        rx        = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("reset_tx", tx, 1'b1);
        chk("reset_ready", din_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_lost", lost, 1'b0);

        // A5 with rx following tx; an en in the acceptance cycle must be ignored
        start_frame(8'hA5, 1'b1);
        run_frame(0, 1'b0, 0);
        cyc();
        chk("done_one_cycle", done, 1'b0);

        start_frame(8'hF8, 1'b0);
        run_frame(0, 1'b0, 0);
        cyc();

        start_frame(8'hFF, 1'b0);
        run_frame(3, 1'b0, 0);
        cyc();
        chk("lost_one_cycle", lost, 1'b0);
        chk("idle_tx_after_loss", tx, 1'b1);

        start_frame(8'h00, 1'b0);
        run_frame(0, 1'b1, 0);
        cyc();

        start_frame(8'h5A, 1'b0);
        run_frame(0, 1'b0, 4);
        start_frame(8'hC3, 1'b0);
        run_frame(0, 1'b0, 0);
        cyc();

        // queued frame held while busy, accepted in the done cycle
        start_frame(8'h96, 1'b0);
        din       = 8'h3C;
        din_valid = 1'b1;
        run_frame(0, 1'b0, 0);
        cyc();
        din_valid = 1'b0;
        din       = 8'($urandom);
        build(8'h3C);
        run_frame(0, 1'b0, 0);
        cyc();

        for (int n = 0; n < 20; n++) begin
            start_frame(8'($urandom), 1'($urandom_range(0, 1)));
            run_frame($urandom_range(0, 12), 1'b0, 0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
